aes128_decrypt_iter: RTL and testbench



---
 rtl/aes128_decrypt_iter_if.sv | 25 ++
 rtl/aes128_decrypt_iter.sv | 208 ++++++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_decrypt_iter_if.sv
// Request/result bundle for the iterative AES-128 decryptor.
// Handshake: the master holds start high with ciphertext/key valid; the core
// accepts it on the first rising edge where it is idle (busy low). The core
// pulses done for exactly one cycle when plaintext is valid. plaintext then
// holds until the next accepted start completes. dbg_state mirrors the FSM
// state for observation only.
interface aes128_decrypt_iter_if;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;
    logic [2:0]   dbg_state;

    modport master (
        output start, ciphertext, key,
        input  busy, done, plaintext, dbg_state
    );

    modport slave (
        input  start, ciphertext, key,
        output busy, done, plaintext, dbg_state
    );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption: one round per clock. Round keys are derived on
// the fly, first forward to round key 10, then backwards down to round key 0.
// Latency from accepted start to done is 21 clocks.
module aes128_decrypt_iter #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes128_decrypt_iter_if.slave  io_bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXPAND = 3'd1,
        S_KEYADD = 3'd2,
        S_ROUND  = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    // Tables are listed entry 0 first, so entry x sits at packed index ~x.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ {rc, 24'h0}
    function automatic logic [31:0] key_core(input logic [31:0] w, input logic [7:0] rc);
        return {SBOX[~w[23:16]] ^ rc, SBOX[~w[15:8]], SBOX[~w[7:0]], SBOX[~w[31:24]]};
    endfunction

    function automatic logic [127:0] fwd_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ key_core(rk[31:0], rc);
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = rk[31:0] ^ rk[63:32];
        n2 = rk[63:32] ^ rk[95:64];
        n1 = rk[95:64] ^ rk[127:96];
        n0 = rk[127:96] ^ key_core(n3, rc);
        return {n0, n1, n2, n3};
    endfunction

    // Byte (row r, column c) lives at index 4*c + r, byte 0 in the MSBs.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = INV_SBOX[~s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) product of a with a 4-bit constant m.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    state_t       r_state;
    logic [3:0]   r_rc;
    logic [127:0] r_st;
    logic [127:0] r_rk;
    logic [127:0] r_pt;
    logic         r_busy;
    logic         r_done;

    logic [127:0] w_rk_fwd;
    logic [127:0] w_rk_inv;
    logic [127:0] w_addk;
    logic [127:0] w_mix;

    // r_rc selects the Rcon for both directions: in KEYADD it still holds NR,
    // in ROUND it is the index of the round key currently in r_rk.
    assign w_rk_fwd = fwd_expand(r_rk, rcon(r_rc));
    assign w_rk_inv = inv_expand(r_rk, rcon(r_rc));
    assign w_addk   = inv_shift_sub(r_st) ^ r_rk;
    assign w_mix    = inv_mix_columns(w_addk);

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.plaintext = r_pt;
    assign io_bus.dbg_state = r_state;

    // Control FSM together with the round datapath and key schedule registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rc    <= 4'd0;
            r_st    <= '0;
            r_rk    <= '0;
            r_pt    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_st    <= io_bus.ciphertext;
                        r_rk    <= io_bus.key;
                        r_rc    <= 4'd1;
                        r_busy  <= 1'b1;
                        r_state <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    r_rk <= w_rk_fwd;
                    if (r_rc == 4'(NR)) begin
                        r_state <= S_KEYADD;
                    end else begin
                        r_rc <= r_rc + 4'd1;
                    end
                end
                S_KEYADD: begin
                    r_st    <= r_st ^ r_rk;
                    r_rk    <= w_rk_inv;
                    r_rc    <= 4'(NR - 1);
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_st <= w_mix;
                    r_rk <= w_rk_inv;
                    if (r_rc == 4'd1) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_rc <= r_rc - 4'd1;
                    end
                end
                S_FINAL: begin
                    r_pt    <= w_addk;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_rc    <= 4'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: known-answer table, corner-case sequences and
// a round trip through a small behavioural AES-128 encryptor.
module tb_aes128_decrypt_iter;

    logic clk;
    logic rst_n;

    aes128_decrypt_iter_if bus();

    aes128_decrypt_iter #(.NR(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs[4];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    // Forward S-box for the reference encryptor, entry x at packed index ~x.
    localparam logic [255:0][7:0] SB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] m_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = SB[~s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
            o[103 - 32*c -: 8] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] m_key_next(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {SB[~rk[23:16]] ^ rc, SB[~rk[15:8]], SB[~rk[7:0]], SB[~rk[31:24]]};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Behavioural AES-128 encryption, used to produce round-trip ciphertexts.
    function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, rk;
        logic [7:0]   rc;
        rk = key;
        s  = pt ^ rk;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            s = m_sub_shift(s);
            if (r != 10) s = m_mix(s);
            rk = m_key_next(rk, rc);
            s  = s ^ rk;
            rc = m_xt(rc);
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One full operation from an idle core: latency, busy width, held output,
    // result and single-cycle done.
    task automatic do_vec(input string name, input logic [127:0] ct, input logic [127:0] key,
                          input logic [127:0] exp);
        logic [127:0] pt0;
        int           lat;
        int           bc;
        logic         stable;
        @(negedge clk);
        bus.ciphertext = ct;
        bus.key        = key;
        bus.start      = 1'b1;
        pt0            = bus.plaintext;
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 0;
        bc        = 0;
        stable    = 1'b1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) bc++;
            if (bus.plaintext !== pt0) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 128'(lat), 128'd21);
        chk({name, "_busy_cycles"}, 128'(bc), 128'd21);
        chk({name, "_pt_held_while_busy"}, 128'(stable), 128'd1);
        chk({name, "_plaintext"}, bus.plaintext, exp);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 128'(bus.done), 128'd0);
        chk({name, "_idle_after"}, 128'(bus.busy), 128'd0);
        chk({name, "_pt_held_after"}, bus.plaintext, exp);
    endtask

    initial begin
        logic [127:0] rpt;
        logic [127:0] rkey;
        logic [127:0] dpt [2];
        int           dcyc [2];
        int           dcnt;

        vecs[0] = '{"fips_c1", C1_KEY, C1_CT, C1_PT};
        vecs[1] = '{"fips_b", B_KEY, B_CT, B_PT};
        vecs[2] = '{"zero", 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
        vecs[3] = '{"ecb_blk1", B_KEY, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    128'h6bc1bee22e409f96e93d7e117393172a};

        // Reset
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.ciphertext = '0;
        bus.key        = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_done", 128'(bus.done), 128'd0);
        chk("reset_plaintext", bus.plaintext, 128'd0);
        chk("reset_state", 128'(bus.dbg_state), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer table
        for (int i = 0; i < 4; i++) begin
            do_vec(vecs[i].name, vecs[i].ct, vecs[i].key, vecs[i].pt);
        end

        // Start while busy: a second request with other data must be ignored
        @(negedge clk);
        bus.ciphertext = C1_CT;
        bus.key        = C1_KEY;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dcnt      = 0;
        dcyc[0]   = -1;
        dpt[0]    = '0;
        for (int n = 0; n < 50; n++) begin
            if (bus.done === 1'b1) begin
                if (dcnt == 0) begin
                    dcyc[0] = n;
                    dpt[0]  = bus.plaintext;
                end
                dcnt++;
            end
            if (n == 5) begin
                bus.start      = 1'b1;
                bus.ciphertext = B_CT;
                bus.key        = B_KEY;
            end
            if (n == 6) bus.start = 1'b0;
            @(negedge clk);
        end
        chk("busy_start_done_count", 128'(dcnt), 128'd1);
        chk("busy_start_done_cycle", 128'(dcyc[0]), 128'd21);
        chk("busy_start_plaintext", dpt[0], C1_PT);

        // Reset in the middle of an operation
        @(negedge clk);
        bus.ciphertext = B_CT;
        bus.key        = B_KEY;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        chk("midop_busy_before_reset", 128'(bus.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_busy", 128'(bus.busy), 128'd0);
        chk("midop_reset_done", 128'(bus.done), 128'd0);
        chk("midop_reset_plaintext", bus.plaintext, 128'd0);
        chk("midop_reset_state", 128'(bus.dbg_state), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt  = 0;
        for (int n = 0; n < 25; n++) begin
            if (bus.done === 1'b1) dcnt++;
            @(negedge clk);
        end
        chk("midop_no_done_after_reset", 128'(dcnt), 128'd0);
        chk("midop_plaintext_stays_zero", bus.plaintext, 128'd0);
        do_vec("after_reset_c1", C1_CT, C1_KEY, C1_PT);

        // Back-to-back with start held high
        @(negedge clk);
        bus.ciphertext = C1_CT;
        bus.key        = C1_KEY;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.ciphertext = B_CT;
        bus.key        = B_KEY;
        dcnt           = 0;
        dcyc[0]        = -1;
        dcyc[1]        = -1;
        dpt[0]         = '0;
        dpt[1]         = '0;
        for (int n = 0; n < 60; n++) begin
            if (bus.done === 1'b1) begin
                if (dcnt < 2) begin
                    dcyc[dcnt] = n;
                    dpt[dcnt]  = bus.plaintext;
                end
                dcnt++;
                if (dcnt == 2) bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("b2b_done_count", 128'(dcnt), 128'd2);
        chk("b2b_first_done_cycle", 128'(dcyc[0]), 128'd21);
        chk("b2b_done_spacing", 128'(dcyc[1] - dcyc[0]), 128'd22);
        chk("b2b_first_plaintext", dpt[0], C1_PT);
        chk("b2b_second_plaintext", dpt[1], B_PT);
        chk("b2b_idle_after", 128'(bus.busy), 128'd0);

        // Round trip through the behavioural encryptor
        for (int i = 0; i < 100; i++) begin
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            do_vec("roundtrip", m_encrypt(rpt, rkey), rkey, rpt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
